// File: rtl/ushift_pkg.sv
// Shared definitions for the universal shift register.
// Holds the shift/rotate mode encodings and the burst FSM state encoding.
package ushift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_SLL  = 3'd1;
  localparam logic [2:0] MODE_SRL  = 3'd2;
  localparam logic [2:0] MODE_SRA  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_ROR  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } st_t;

endpackage

// File: rtl/ushift_core.sv
// Combinational shift/rotate datapath, one STEP-bit move per evaluation.
// Ports:
//   q        in  WIDTH  current register contents
//   shiftin  in  STEP   serial fill bits (logical shifts only)
//   mode     in  3      operation select (6-7 behave as hold)
//   q_nxt    out WIDTH  register value after one step
//   shiftout out STEP   bits that leave the register on this step
module ushift_core
  import ushift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] q,
  input  logic [STEP-1:0]  shiftin,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] q_nxt,
  output logic [STEP-1:0]  shiftout
);

  always_comb begin
    q_nxt = q;
    case (mode)
      MODE_SLL: q_nxt = {q[WIDTH-1-STEP:0], shiftin};
      MODE_SRL: q_nxt = {shiftin, q[WIDTH-1:STEP]};
      MODE_SRA: q_nxt = {{STEP{q[WIDTH-1]}}, q[WIDTH-1:STEP]};
      MODE_ROL: q_nxt = {q[WIDTH-1-STEP:0], q[WIDTH-1-:STEP]};
      MODE_ROR: q_nxt = {q[STEP-1:0], q[WIDTH-1:STEP]};
      default:  q_nxt = q;
    endcase
  end

  // Left-moving ops lose the top bits, everything else the bottom bits.
  assign shiftout = (mode == MODE_SLL || mode == MODE_ROL) ? q[WIDTH-1-:STEP]
                                                           : q[STEP-1:0];

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step and counted-burst operation.
// Optional feature: define USHIFT_PARITY_EN to add the parity output (^q).
// Ports:
//   clk            rising-edge clock
//   aclr / aset    async active-high clear / set (aclr wins)
//   sclr/sset/load sync clear / set / parallel load (in that priority)
//   enable         step qualifier: one step in IDLE, advances a burst
//   data           parallel load value
//   shiftin        fill bits for logical shifts
//   mode           0 hold, 1 SLL, 2 SRL, 3 SRA, 4 ROL, 5 ROR, 6-7 hold
//   start / count  burst request and length, sampled in IDLE only
//   q              register contents
//   shiftout       bits leaving on the next shift (effective mode)
//   busy / done    burst in progress / one-cycle completion pulse
//   parity         ^q (only with USHIFT_PARITY_EN)
module univ_shift_reg
  import ushift_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               STEP        = 1,
  parameter logic [WIDTH-1:0] LOAD_AVALUE = WIDTH'(2),
  parameter logic [WIDTH-1:0] LOAD_SVALUE = WIDTH'(4),
  parameter int               CNT_W       = 4
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             aset,
  input  logic             sclr,
  input  logic             sset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  input  logic [STEP-1:0]  shiftin,
  input  logic [2:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic [STEP-1:0]  shiftout,
  output logic             busy,
  output logic             done
`ifdef USHIFT_PARITY_EN
  ,
  output logic             parity
`endif
);

  st_t              st;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       mode_r;
  logic [2:0]       mode_eff;
  logic [WIDTH-1:0] q_nxt;

  // A running burst uses the mode latched at start; otherwise the live input.
  assign mode_eff = (st == ST_BURST) ? mode_r : mode;

  ushift_core #(.WIDTH(WIDTH), .STEP(STEP)) u_core (
    .q        (q),
    .shiftin  (shiftin),
    .mode     (mode_eff),
    .q_nxt    (q_nxt),
    .shiftout (shiftout)
  );

  always_ff @(posedge clk or posedge aclr or posedge aset) begin
    if (aclr) begin
      q      <= '0;
      st     <= ST_IDLE;
      cnt    <= '0;
      mode_r <= MODE_HOLD;
    end else if (aset) begin
      q      <= LOAD_AVALUE;
      st     <= ST_IDLE;
      cnt    <= '0;
      mode_r <= MODE_HOLD;
    end else if (sclr) begin
      q  <= '0;
      st <= ST_IDLE;
    end else if (sset) begin
      q  <= LOAD_SVALUE;
      st <= ST_IDLE;
    end else if (load) begin
      q  <= data;
      st <= ST_IDLE;
    end else begin
      case (st)
        ST_IDLE: begin
          if (start) begin
            // Zero-length burst skips straight to the completion pulse.
            if (count != '0) begin
              st     <= ST_BURST;
              cnt    <= count;
              mode_r <= mode;
            end else begin
              st <= ST_DONE;
            end
          end else if (enable) begin
            q <= q_nxt;
          end
        end
        ST_BURST: begin
          if (enable) begin
            q   <= q_nxt;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) st <= ST_DONE;
          end
        end
        default: st <= ST_IDLE;  // ST_DONE lasts one cycle; start ignored
      endcase
    end
  end

  assign busy = (st == ST_BURST);
  assign done = (st == ST_DONE);

`ifdef USHIFT_PARITY_EN
  assign parity = ^q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;
  localparam int W  = 8;
  localparam int S  = 1;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          aclr, aset, sclr, sset, load, enable, start;
  logic [W-1:0]  data;
  logic [S-1:0]  shiftin;
  logic [2:0]    mode;
  logic [CW-1:0] count;
  logic [W-1:0]  q;
  logic [S-1:0]  shiftout;
  logic          busy, done;
`ifdef USHIFT_PARITY_EN
  logic          parity;
`endif

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(W), .STEP(S), .CNT_W(CW)) dut (
    .clk(clk), .aclr(aclr), .aset(aset), .sclr(sclr), .sset(sset),
    .load(load), .enable(enable), .data(data), .shiftin(shiftin),
    .mode(mode), .start(start), .count(count), .q(q),
    .shiftout(shiftout), .busy(busy), .done(done)
`ifdef USHIFT_PARITY_EN
    , .parity(parity)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference step computed with integer arithmetic on the register value.
  function automatic int ref_step(int v, int m, int sin);
    int mask = (1 << W) - 1;
    case (m)
      1: return ((v << S) | sin) & mask;
      2: return (v >> S) | (sin << (W - S));
      3: return ((v >> (W - 1)) & 1) ? ((v >> S) | ((((1 << S) - 1)) << (W - S))) : (v >> S);
      4: return ((v << S) | (v >> (W - S))) & mask;
      5: return (v >> S) | ((v << (W - S)) & mask);
      default: return v;
    endcase
  endfunction

  typedef struct {
    logic aset, sclr, sset, load, en;
    logic [W-1:0] data;
    logic sin;
    logic [2:0] mode;
    logic start;
    logic [CW-1:0] cnt;
    logic [W-1:0] eq;
    logic eb, ed;
  } vec_t;

  function automatic vec_t mk(logic as, logic sc, logic ss, logic ld, logic en,
                              logic [W-1:0] d, logic si, logic [2:0] md,
                              logic st, logic [CW-1:0] c,
                              logic [W-1:0] eq, logic eb, logic ed);
    vec_t v;
    v.aset = as; v.sclr = sc; v.sset = ss; v.load = ld; v.en = en;
    v.data = d; v.sin = si; v.mode = md; v.start = st; v.cnt = c;
    v.eq = eq; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  task automatic idle_inputs();
    aclr = 0; aset = 0; sclr = 0; sset = 0; load = 0; enable = 0;
    start = 0; data = '0; shiftin = '0; mode = 3'd0; count = '0;
  endtask

  // Model state: register value, steps left in a burst, pending done pulse.
  int m_q, m_left, m_mode;
  bit m_done;

  task automatic model_edge();
    if (aclr) begin
      m_q = 0; m_left = 0; m_done = 0;
    end else if (aset) begin
      m_q = 2; m_left = 0; m_done = 0;
    end else if (sclr || sset || load) begin
      m_q = sclr ? 0 : sset ? 4 : int'(data);
      m_left = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      if (enable) begin
        m_q = ref_step(m_q, m_mode, int'(shiftin));
        m_left--;
        if (m_left == 0) m_done = 1;
      end
    end else if (start) begin
      if (count != 0) begin
        m_left = int'(count); m_mode = int'(mode);
      end else m_done = 1;
    end else if (enable) begin
      m_q = ref_step(m_q, int'(mode), int'(shiftin));
    end
  endtask

  vec_t vt[$];

  initial begin
    idle_inputs();
    aclr = 1;

    // Both async controls high: random sync activity must have no effect.
    for (int i = 0; i < 50; i++) begin
      aclr = 1; aset = 1;
      sclr = 1'($urandom); sset = 1'($urandom); load = 1'($urandom);
      start = 1'($urandom); enable = 1'($urandom);
      data = W'($urandom); mode = 3'($urandom); count = CW'($urandom);
      @(negedge clk);
      chk("rst q", q, 8'h00);
      chk("rst busy", busy, 1'b0);
      chk("rst done", done, 1'b0);
    end

    //         aset sclr sset load en data  sin mode st cnt  eq    eb ed
    vt.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h02, 0, 0));
    vt.push_back(mk(0, 0, 1, 0, 1, 8'h00, 0, 1, 0, 0, 8'h04, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 8'hA5, 0, 0, 0, 0, 8'hA5, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 8'h00, 0, 3, 0, 0, 8'hD2, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 8'hA5, 0, 0, 0, 0, 8'hA5, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 8'h00, 0, 4, 0, 0, 8'h4B, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 8'h00, 1, 1, 0, 0, 8'h97, 0, 0));
    // burst of 3, ROR
    vt.push_back(mk(0, 0, 0, 1, 0, 8'h81, 0, 0, 0, 0, 8'h81, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 8'h00, 0, 5, 1, 3, 8'h81, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 8'hC0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 8'h60, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 8'h30, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h30, 0, 0));
    // burst of 3 with a 2-cycle enable stall; mode/start/count ignored
    vt.push_back(mk(0, 0, 0, 1, 0, 8'h81, 0, 0, 0, 0, 8'h81, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 8'h00, 0, 5, 1, 3, 8'h81, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 8'h00, 0, 1, 1, 7, 8'hC0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 1, 1, 7, 8'hC0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 2, 0, 0, 8'hC0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 8'h00, 1, 1, 1, 9, 8'h60, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 8'h30, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 5, 1, 2, 8'h30, 0, 0));
    // burst of 5 aborted by sclr
    vt.push_back(mk(0, 0, 0, 1, 0, 8'h81, 0, 0, 0, 0, 8'h81, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 8'h00, 0, 5, 1, 5, 8'h81, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 8'hC0, 1, 0));
    vt.push_back(mk(0, 1, 0, 0, 1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));
    // zero-length burst
    vt.push_back(mk(0, 0, 0, 1, 0, 8'h5A, 0, 0, 0, 0, 8'h5A, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 8'h00, 0, 5, 1, 0, 8'h5A, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h5A, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 8'hA4, 0, 0, 0, 0, 8'hA4, 0, 0));

    for (int i = 0; i < vt.size(); i++) begin
      idle_inputs();
      aset = vt[i].aset; sclr = vt[i].sclr; sset = vt[i].sset;
      load = vt[i].load; enable = vt[i].en; data = vt[i].data;
      shiftin = vt[i].sin; mode = vt[i].mode; start = vt[i].start;
      count = vt[i].cnt;
      @(negedge clk);
      chk($sformatf("v%0d q", i), q, vt[i].eq);
      chk($sformatf("v%0d busy", i), busy, vt[i].eb);
      chk($sformatf("v%0d done", i), done, vt[i].ed);
`ifdef USHIFT_PARITY_EN
      chk($sformatf("v%0d parity", i), parity, ^vt[i].eq);
`endif
    end

    // Randomized run against the model, starting from a known reset.
    idle_inputs();
    aclr = 1;
    model_edge();
    @(negedge clk);
    for (int i = 0; i < 600; i++) begin
      aclr    = ($urandom_range(0, 63) == 0);
      aset    = ($urandom_range(0, 47) == 0);
      sclr    = ($urandom_range(0, 31) == 0);
      sset    = ($urandom_range(0, 31) == 0);
      load    = ($urandom_range(0, 15) == 0);
      enable  = ($urandom_range(0, 3) != 0);
      start   = ($urandom_range(0, 5) == 0);
      data    = W'($urandom);
      shiftin = S'($urandom);
      mode    = 3'($urandom);
      count   = CW'($urandom_range(0, 6));
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk($sformatf("r%0d q", i), q, m_q[W-1:0]);
      chk($sformatf("r%0d busy", i), busy, m_left > 0);
      chk($sformatf("r%0d done", i), done, m_done);
      if (m_left == 0 && !aclr && !aset)
        chk($sformatf("r%0d shiftout", i), shiftout,
            (mode == 3'd1 || mode == 3'd4) ? (m_q >> (W - S)) & ((1 << S) - 1)
                                            : m_q & ((1 << S) - 1));
`ifdef USHIFT_PARITY_EN
      chk($sformatf("r%0d parity", i), parity, ^m_q[W-1:0]);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
